// File: rtl/execute_stage.sv
// RV32I Execute stage: operand forwarding, ALU, branch/jump resolution and the
// EX/MEM pipeline register feeding the Memory stage.
module execute_stage #(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               StallM,
  input  logic               FlushM,
  input  logic               RegWriteE,
  input  logic               MemWriteE,
  input  logic               a_typeE,
  input  logic               JumpE,
  input  logic               BranchE,
  input  logic               JalrE,
  input  logic               ALUSrcE,
  input  logic [1:0]         ResultSrcE,
  input  logic [3:0]         ALUControlE,
  input  logic [2:0]         funct3E,
  input  logic [D_WIDTH-1:0] RD1E,
  input  logic [D_WIDTH-1:0] RD2E,
  input  logic [D_WIDTH-1:0] ImmExtE,
  input  logic [D_WIDTH-1:0] PCE,
  input  logic [D_WIDTH-1:0] PCPlus4E,
  input  logic [A_WIDTH-1:0] RdE,
  input  logic [1:0]         ForwardAE,
  input  logic [1:0]         ForwardBE,
  input  logic [D_WIDTH-1:0] ResultW,
  input  logic [D_WIDTH-1:0] ALUResultM_fwd,
  output logic               PCSrcE,
  output logic [D_WIDTH-1:0] PCTargetE,
  output logic [A_WIDTH-1:0] RdE_o,
  output logic               RegWriteM,
  output logic               MemWriteM,
  output logic               a_typeM,
  output logic [1:0]         ResultSrcM,
  output logic [D_WIDTH-1:0] ALUResultM,
  output logic [D_WIDTH-1:0] WriteDataM,
  output logic [D_WIDTH-1:0] PCPlus4M,
  output logic [A_WIDTH-1:0] RdM
);

  logic [D_WIDTH-1:0] w_srca, w_wdata, w_srcb, w_alu, w_jalr_sum;
  logic [4:0]         w_shamt;
  logic               w_eq, w_lt, w_ltu, w_taken;

  // Select 11 deliberately falls back to the register-file value.
  always_comb begin
    w_srca = RD1E;
    case (ForwardAE)
      2'b01:   w_srca = ResultW;
      2'b10:   w_srca = ALUResultM_fwd;
      default: w_srca = RD1E;
    endcase
    w_wdata = RD2E;
    case (ForwardBE)
      2'b01:   w_wdata = ResultW;
      2'b10:   w_wdata = ALUResultM_fwd;
      default: w_wdata = RD2E;
    endcase
  end

  assign w_srcb  = ALUSrcE ? ImmExtE : w_wdata;
  assign w_shamt = w_srcb[4:0];

  always_comb begin
    w_alu = '0;
    case (ALUControlE)
      4'b0000: w_alu = w_srca + w_srcb;
      4'b0001: w_alu = w_srca - w_srcb;
      4'b0010: w_alu = w_srca & w_srcb;
      4'b0011: w_alu = w_srca | w_srcb;
      4'b0100: w_alu = w_srca ^ w_srcb;
      4'b0101: w_alu = {{(D_WIDTH-1){1'b0}}, $signed(w_srca) < $signed(w_srcb)};
      4'b0110: w_alu = {{(D_WIDTH-1){1'b0}}, w_srca < w_srcb};
      4'b0111: w_alu = w_srca << w_shamt;
      4'b1000: w_alu = w_srca >> w_shamt;
      4'b1001: w_alu = $unsigned($signed(w_srca) >>> w_shamt);
      4'b1010: w_alu = w_srcb;
      default: w_alu = '0;
    endcase
  end

  // Branches always compare register operands, never the immediate.
  assign w_eq  = (w_srca == w_wdata);
  assign w_lt  = ($signed(w_srca) < $signed(w_wdata));
  assign w_ltu = (w_srca < w_wdata);

  always_comb begin
    w_taken = 1'b0;
    case (funct3E)
      3'b000:  w_taken = w_eq;
      3'b001:  w_taken = ~w_eq;
      3'b100:  w_taken = w_lt;
      3'b101:  w_taken = ~w_lt;
      3'b110:  w_taken = w_ltu;
      3'b111:  w_taken = ~w_ltu;
      default: w_taken = 1'b0;
    endcase
  end

  assign w_jalr_sum = w_srca + ImmExtE;
  assign PCSrcE     = JumpE | (BranchE & w_taken);
  assign PCTargetE  = JalrE ? {w_jalr_sum[D_WIDTH-1:1], 1'b0} : (PCE + ImmExtE);
  assign RdE_o      = RdE;

  logic               r_regw, r_memw, r_atype;
  logic [1:0]         r_rsrc;
  logic [D_WIDTH-1:0] r_alu, r_wdata, r_pc4;
  logic [A_WIDTH-1:0] r_rd;

  // Flush beats stall so a squashed instruction can never be held in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regw <= 1'b0; r_memw <= 1'b0; r_atype <= 1'b0; r_rsrc <= '0;
      r_alu  <= '0;   r_wdata <= '0;  r_pc4   <= '0;   r_rd   <= '0;
    end else if (FlushM) begin
      r_regw <= 1'b0; r_memw <= 1'b0; r_atype <= 1'b0; r_rsrc <= '0;
      r_alu  <= '0;   r_wdata <= '0;  r_pc4   <= '0;   r_rd   <= '0;
    end else if (!StallM) begin
      r_regw  <= RegWriteE;
      r_memw  <= MemWriteE;
      r_atype <= a_typeE;
      r_rsrc  <= ResultSrcE;
      r_alu   <= w_alu;
      r_wdata <= w_wdata;
      r_pc4   <= PCPlus4E;
      r_rd    <= RdE;
    end
  end

  assign RegWriteM  = r_regw;
  assign MemWriteM  = r_memw;
  assign a_typeM    = r_atype;
  assign ResultSrcM = r_rsrc;
  assign ALUResultM = r_alu;
  assign WriteDataM = r_wdata;
  assign PCPlus4M   = r_pc4;
  assign RdM        = r_rd;

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- RV32I pipeline Execute stage. It sits between the ID/EX register and memory_stage.
- Applies operand forwarding, runs the ALU, and resolves branches and jumps.
- Computes the branch/jump target.
- Registers the EX/MEM pipeline state that feeds the Memory stage: control bits, ALU result, store data, Rd and PC+4.

Parameters:
- D_WIDTH, 32, datapath width
- A_WIDTH, 5, register address width

Ports:
- clk  in  1  clock; all registers update on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- StallM  in  1  hold the EX/MEM register contents
- FlushM  in  1  load a bubble into the EX/MEM register
- RegWriteE, MemWriteE, a_typeE, JumpE, BranchE, JalrE, ALUSrcE  in  1 each  decoded control from the ID/EX register
- ResultSrcE  in  2  writeback source select
- ALUControlE  in  4  ALU operation
- funct3E  in  3  branch condition
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  in  D_WIDTH  operands and PC values
- RdE  in  A_WIDTH  destination register
- ForwardAE, ForwardBE  in  2  forwarding selects from the hazard unit
- ResultW  in  D_WIDTH  Writeback result, for forwarding
- ALUResultM_fwd  in  D_WIDTH  Memory-stage ALU result, for forwarding
- PCSrcE  out  1  redirect fetch (combinational)
- PCTargetE  out  D_WIDTH  redirect target (combinational)
- RdE_o  out  A_WIDTH  RdE passthrough, for the hazard unit
- RegWriteM, MemWriteM, a_typeM  out  1 each  registered control
- ResultSrcM  out  2  registered control
- ALUResultM, WriteDataM, PCPlus4M  out  D_WIDTH  registered data
- RdM  out  A_WIDTH  registered destination

Behaviour:
- Forwarding, applied separately to each operand:
  - 00 selects RD1E/RD2E.
  - 01 selects ResultW.
  - 10 selects ALUResultM_fwd.
  - 11 is treated as 00.
- SrcA is the forwarded A operand.
- WriteDataE is the forwarded B operand.
- SrcB is ImmExtE when ALUSrcE=1, otherwise WriteDataE.
- ALU (ALUControlE), all results mod 2^D_WIDTH:
  - 0000 ADD
  - 0001 SUB
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 SLT (signed, zero-extended 0/1)
  - 0110 SLTU
  - 0111 SLL
  - 1000 SRL
  - 1001 SRA
  - 1010 PASS SrcB (LUI)
  - all other codes produce 0
  - shift amount is SrcB[4:0]
- Branch compare on SrcA vs WriteDataE, selected by funct3E:
  - 000 EQ
  - 001 NE
  - 100 LT signed
  - 101 GE signed
  - 110 LTU
  - 111 GEU
  - other codes: not taken
- PCSrcE = JumpE | (BranchE & taken). It is combinational in the same cycle and is not affected by StallM or FlushM.
- PCTargetE:
  - JalrE=1: (SrcA + ImmExtE) with bit 0 cleared.
  - otherwise: PCE + ImmExtE.
- RdE_o = RdE, combinational.
- EX/MEM register update at the rising clk edge, in priority order:
  1. rst_n=0 (asynchronous, immediate, no clock needed): all M outputs become 0.
  2. FlushM=1: all M outputs are loaded with 0 (bubble: RegWriteM=0, MemWriteM=0). FlushM overrides StallM.
  3. StallM=1: all M outputs hold.
  4. Otherwise: load the E values. ALUResultM gets the ALU result, WriteDataM gets the forwarded B operand, the rest pass straight through.
- Latency: E inputs appear on the M outputs one cycle later.
- Reset deasserted mid-operation: the first edge after deassertion loads normally.
- No combinational path from any input to the M outputs.

Test Plan:
- rst_n=0 asserted between clock edges with nonzero state → all M outputs read 0 immediately. After release, ADD with RD1E=5, RD2E=7, ALUSrcE=0 → ALUResultM=12 one cycle later.
- Forwarding: RD1E=1, ForwardAE=10, ALUResultM_fwd=100, ImmExtE=4, ALUSrcE=1, ADD → ALUResultM=104. ForwardBE=01, ResultW=0xAB, MemWriteE=1 → WriteDataM=0xAB.
- ALU edges:
  - SUB 0-1 → 0xFFFFFFFF
  - SLT 0xFFFFFFFF vs 1 → 1
  - SLTU of the same operands → 0
  - SRA 0x80000000 by 31 → 0xFFFFFFFF
  - SLL by SrcB=33 → shift by 1
- Branches:
  - BLT -1 vs 1 → PCSrcE=1 and PCTargetE=PCE+ImmExtE in the same cycle.
  - BLTU of the same operands → PCSrcE=0.
  - JALR with SrcA=0x1001, Imm=2 → PCTargetE=0x1002.
- StallM=1 for 2 cycles with changing E inputs → M outputs held. FlushM=1 together with StallM=1 → next edge gives RegWriteM=0, MemWriteM=0 and all data 0.
- Back-to-back: 3 consecutive instructions with no stall → M outputs follow in order with exactly 1-cycle latency each.
